// File: rtl/alu_writeback_pkg.sv
// Shared definitions for the ALU writeback stage: P bit positions,
// destination codes and the computed-flag bundle.
package alu_writeback_pkg;

  localparam int unsigned CARRY  = 0;
  localparam int unsigned ZERO   = 1;
  localparam int unsigned IRQ    = 2;
  localparam int unsigned DEC    = 3;
  localparam int unsigned BRK    = 4;
  localparam int unsigned UNUSED = 5;
  localparam int unsigned OVF    = 6;
  localparam int unsigned NEG    = 7;

  typedef enum logic [1:0] {
    DEST_A    = 2'd0,
    DEST_X    = 2'd1,
    DEST_Y    = 2'd2,
    DEST_NONE = 2'd3
  } dest_t;

  typedef struct packed {
    logic n;
    logic v;
    logic z;
    logic c;
  } flags_t;

  // P bits an ALU result is allowed to update.
  localparam logic [7:0] ALU_FLAG_BITS = 8'b1100_0011;

endpackage

// File: rtl/alu_writeback_flag_calc.sv
// Combinational N/V/Z/C derivation from an ALU result and its operand MSBs.
module wb_flag_calc
  import alu_writeback_pkg::*;
(
  input  logic [7:0] alu_y,
  input  logic       carry,
  input  logic       ai_msb,
  input  logic       bi_msb,
  output flags_t     flags
);

  always_comb begin
    flags   = '0;
    flags.n = alu_y[7];
    flags.z = (alu_y == 8'h00);
    flags.c = carry;
    // Signed overflow: both operands disagree in sign with the result.
    flags.v = (ai_msb ^ alu_y[7]) & (bi_msb ^ alu_y[7]);
  end

endmodule

// File: rtl/alu_writeback.sv
// Commits ALU results into A/X/Y and owns every write path into P
// (ALU flags, explicit flag ops, PLP and interrupt entry).
module alu_writeback
  import alu_writeback_pkg::*;
#(
  parameter logic [7:0] P_RESET   = 8'h24,
  parameter logic [7:0] REG_RESET = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wb_valid,
  output logic       wb_ready,
  input  logic [1:0] wb_dest,
  input  logic [7:0] wb_flag_mask,
  input  logic [7:0] alu_Y,
  input  logic [7:0] alu_flags,
  input  logic       op_ai_msb,
  input  logic       op_bi_msb,
  input  logic       flag_op_valid,
  input  logic [7:0] flag_op_mask,
  input  logic       flag_op_val,
  input  logic       plp_valid,
  input  logic [7:0] plp_data,
  input  logic       irq_entry,
  input  logic       brk_push,
  output logic [7:0] reg_a,
  output logic [7:0] reg_x,
  output logic [7:0] reg_y,
  output logic [7:0] p_reg,
  output logic [7:0] p_push,
  output logic       commit_valid
);

  flags_t     calc;
  logic [7:0] calc_p;
  logic [7:0] alu_mask;
  logic [7:0] p_next;
  logic       accept;

  wb_flag_calc u_flag_calc (
    .alu_y  (alu_Y),
    .carry  (alu_flags[CARRY]),
    .ai_msb (op_ai_msb),
    .bi_msb (op_bi_msb),
    .flags  (calc)
  );

  assign wb_ready = !plp_valid;
  assign accept   = wb_valid && wb_ready;

  always_comb begin
    calc_p         = '0;
    calc_p[CARRY]  = calc.c;
    calc_p[ZERO]   = calc.z;
    calc_p[OVF]    = calc.v;
    calc_p[NEG]    = calc.n;
    alu_mask       = wb_flag_mask & ALU_FLAG_BITS;

    p_next = p_reg;
    if (plp_valid) begin
      p_next = plp_data;
    end else begin
      // Later writers overwrite earlier ones: ALU, then flag op, then IRQ.
      if (accept)
        p_next = (p_next & ~alu_mask) | (calc_p & alu_mask);
      if (flag_op_valid)
        p_next = (p_next & ~flag_op_mask) | ({8{flag_op_val}} & flag_op_mask);
      if (irq_entry)
        p_next[IRQ] = 1'b1;
    end
    p_next[UNUSED] = 1'b1;
    p_next[BRK]    = 1'b0;
  end

  always_comb begin
    p_push         = p_reg;
    p_push[UNUSED] = 1'b1;
    p_push[BRK]    = brk_push;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg_a        <= REG_RESET;
      reg_x        <= REG_RESET;
      reg_y        <= REG_RESET;
      p_reg        <= P_RESET;
      commit_valid <= 1'b0;
    end else begin
      p_reg        <= p_next;
      commit_valid <= accept;
      if (accept) begin
        case (dest_t'(wb_dest))
          DEST_A:    reg_a <= alu_Y;
          DEST_X:    reg_x <= alu_Y;
          DEST_Y:    reg_y <= alu_Y;
          default:   ;
        endcase
      end
    end
  end

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
Downstream stage of the ALU in the 6502 core: accepts each ALU result with a destination and a flag-update mask, and commits it to the architectural registers A, X and Y and the processor status register P. It computes Z, N and V from the result and operands, and takes C from the ALU. It also owns every other write path into P: SEC/CLC-style flag ops, PLP loads and interrupt entry.

Parameters:
P_RESET, 8'h24, reset value of P (I=1, bit5=1, all others 0).
REG_RESET, 8'h00, reset value of A, X and Y.

Ports:
clk  in  1  core clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
wb_valid  in  1  upstream presents an ALU result this cycle
wb_ready  out  1  stage can accept the result this cycle
wb_dest  in  2  0=A, 1=X, 2=Y, 3=none (flags only, e.g. CMP/BIT)
wb_flag_mask  in  8  per-bit enable for P update, bit positions from params.vh
alu_Y  in  8  ALU result
alu_flags  in  8  ALU flag outputs; only the CARRY bit is consumed
op_ai_msb  in  1  bit 7 of the ALU AI operand
op_bi_msb  in  1  bit 7 of the ALU BI operand (already inverted by upstream for SBC)
flag_op_valid  in  1  explicit flag set/clear (SEC/CLC/SEI/CLI/SED/CLD/CLV)
flag_op_mask  in  8  bits to modify
flag_op_val  in  1  value written to the masked bits
plp_valid  in  1  load P from the stack
plp_data  in  8  byte pulled from the stack
irq_entry  in  1  interrupt/BRK entry; sets I
brk_push  in  1  1 selects B=1 in p_push (BRK/PHP), 0 selects B=0 (IRQ/NMI)
reg_a, reg_x, reg_y  out  8 each  architectural registers
p_reg  out  8  status register
p_push  out  8  P formatted for a stack push
commit_valid  out  1  pulses for 1 cycle after each accepted result

Behaviour:
- Reset (rst_n=0 at an edge): reg_a, reg_x, reg_y = REG_RESET; p_reg = P_RESET; commit_valid = 0. Reset overrides all inputs in the same cycle, including a result in flight. wb_ready is combinational and still obeys the rule below during reset.
- Bit layout of P: C=0, Z=1, I=2, D=3, B=4, bit5=5, V=6, N=7.
  - p_reg bit5 is always 1. p_reg bit B is always 0; it is not stored.
  - p_push = p_reg with bit5=1 and B=brk_push; it is combinational.
- Handshake: wb_ready = !plp_valid. A result is accepted when wb_valid && wb_ready. Upstream holds alu_Y, wb_dest, mask and operands stable until accepted.
- Accept, with a single register stage:
  - Destination register <= alu_Y at the accepting edge. wb_dest=3 writes no register.
  - Computed flags: Z = (alu_Y==0); N = alu_Y[7]; C = alu_flags[CARRY]; V = (op_ai_msb ^ alu_Y[7]) & (op_bi_msb ^ alu_Y[7]).
  - For each bit set in wb_flag_mask, that P bit <= the computed flag. Mask bits for I, D, B and bit5 are ignored.
  - commit_valid = 1 in the cycle after the accepting edge, otherwise 0. Latency from accept to visible register is 1 cycle.
- Priority when events share a cycle, highest first:
  - rst_n.
  - plp_valid: p_reg <= plp_data with B forced 0 and bit5 forced 1. The ALU result is not accepted (wb_ready=0). flag_op and irq_entry are ignored that cycle.
  - ALU result: its masked flag bits are applied first.
  - flag_op_valid: overrides the ALU value on any bit it also masks.
  - irq_entry: I <= 1, and it wins over a flag_op on I.
  - Unmasked bits hold their value.
- A flag op, irq_entry and an ALU result in the same cycle are all applied, each to its own bits.
- No internal buffering beyond the destination registers. Back-to-back accepts every cycle are supported, with full throughput.

Decomposition:
- Bit positions CARRY, ZERO, IRQ, DEC, BRK, UNUSED, OVF, NEG and the destination codes DEST_A/X/Y/NONE belong in the shared includes/params.vh, next to the ALU op codes.
- One sub-module is natural: wb_flag_calc, combinational, alu_Y/carry/operand MSBs -> {N, V, Z, C}.
- The P register and its priority merge stay in alu_writeback.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with wb_valid=1 -> reg_a/x/y=00, p_reg=24, commit_valid=0, p_push=24 with brk_push=0 and 34 with brk_push=1.
- ADC overflow: alu_Y=80, carry=0, ai_msb=0, bi_msb=0, dest=A, mask=C|Z|V|N -> next cycle reg_a=80, p_reg=E4 (N,V set), commit_valid=1 for 1 cycle.
- CMP flags-only: alu_Y=00, carry=1, dest=3, mask=C|Z|N -> reg_a/x/y unchanged, p_reg Z=1, C=1, N=0.
- PLP collision: plp_valid=1 with plp_data=FF and wb_valid=1 -> wb_ready=0, p_reg=EF. The result is accepted the next cycle when plp_valid=0.
- Same-cycle merge: ALU mask=C with carry=1, plus flag_op CLC and irq_entry -> C=0, I=1, all other bits unchanged.
- Throughput: 4 consecutive accepts to X with 01, 02, 03, 00 -> reg_x follows each value one cycle later, commit_valid high 4 cycles, Z=1 only after the last.
